// File: rtl/label_ram_writer_pkg.sv
// ==== label_ram_writer_pkg: shared widths, FSM states and window helper (rev 1.0) ====
`default_nettype none

package label_ram_writer_pkg;

  localparam int LBL_ADDR_W = 8;
  localparam int LBL_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_WRITE  = 2'd2
  } wr_state_t;

  function automatic logic in_window(input logic [9:0] y, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (y >= lo) && (y < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/label_ram_writer_sync_fifo.sv
// ==== sync_fifo: single-clock FIFO with occupancy count (rev 1.0) ====
`default_nettype none

module sync_fifo
  import label_ram_writer_pkg::*;
#(
  parameter int W     = LBL_ADDR_W + LBL_DATA_W,
  parameter int DEPTH = 16
) (
  input  logic                     px_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge px_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/label_ram_writer.sv
// ==== label_ram_writer: buffers host writes, commits them to label RAM in vblank (rev 1.0) ====
`default_nettype none

module label_ram_writer
  import label_ram_writer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int GUARD    = 2,
  parameter int MAX_WR   = 64
) (
  input  logic                   px_clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic [9:0]             px_y,
  input  logic [7:0]             vid_addr,
  output logic [7:0]             ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_din,
  output logic                   owns_port,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int BW = $clog2(MAX_WR + 1);
  localparam logic [BW-1:0] BUDGET_MAX = BW'(MAX_WR);
  localparam logic [9:0]    WIN_LO     = 10'(V_ACTIVE);
  localparam logic [9:0]    WIN_HI     = 10'(V_TOTAL - GUARD);

  wr_state_t     state;
  logic          win;
  logic [BW-1:0] budget;
  logic [7:0]    addr_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head;

  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  // Pop and commit happen on the same edge, so ram_we is high exactly for the popped entry.
  assign pop      = win && !empty && (budget < BUDGET_MAX) && (state != ST_CLOSED);
  assign ram_addr = owns_port ? addr_q : vid_addr;

  sync_fifo #(
    .W     (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    ({wr_addr, wr_data}),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (pending)
  );

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLOSED;
      win        <= 1'b0;
      budget     <= '0;
      ram_we     <= 1'b0;
      addr_q     <= '0;
      ram_din    <= '0;
      owns_port  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win        <= in_window(px_y, WIN_LO, WIN_HI);
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      if (pop) begin
        state   <= ST_WRITE;
        ram_we  <= 1'b1;
        addr_q  <= head[15:8];
        ram_din <= head[7:0];
        budget  <= budget + 1'b1;
      end else begin
        case (state)
          ST_CLOSED: begin
            if (win) begin
              state     <= ST_OPEN;
              owns_port <= 1'b1;
              budget    <= '0;
            end
          end
          ST_OPEN, ST_WRITE: begin
            if (!win) begin
              state      <= ST_CLOSED;
              owns_port  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state <= ST_OPEN;
            end
          end
          default: begin
            state     <= ST_CLOSED;
            owns_port <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
